jtdsp16_sio_rx: RTL and testbench

Serial receiver that sits directly downstream of the DSP16 serial output port and turns its bit stream back into parallel words. It samples OutCLK/OutLoad/data/address pins on the same `clk`/`cen` domain as the DSP core, rebuilds each 16-bit word plus its 8-bit serial address, and steers words into left/right sample registers for the Q-Sound mixer. Only the fixed Q-Sound framing is supported: MSB first, 16-bit words, 8 address bits.

---
 rtl/jtdsp16_sio_rx.sv | 122 ++++++++++++
 tb/tb_jtdsp16_sio_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_sio_rx.sv
// DSP16 serial-output receiver: rebuilds 16-bit words and 8-bit addresses, steers left/right samples.
// Optional short-frame error counter enabled with `define JTDSP16_SIORX_ERR_EN.
module jtdsp16_sio_rx #(
   parameter logic [7:0] LEFT_ADDR  = 8'h00,
   parameter logic [7:0] RIGHT_ADDR = 8'h01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        ock,
   input  logic        sio_do,
   input  logic        sadd,
   input  logic        old,
   output logic [15:0] word,
   output logic [7:0]  word_addr,
   output logic        word_valid,
   output logic [15:0] left,
   output logic [15:0] right,
   output logic        sample,
   output logic [7:0]  err_cnt
);

   logic        ock_l;
   logic [3:0]  bcnt;
   logic [15:0] shr;
   logic [7:0]  ashr;
   logic        lpend;
   logic        vld_p1;
   logic        smp_p1;

   logic        rise;
   logic        take;
   logic        done;
   logic        short_frm;
   logic [15:0] word_nxt;
   logic        is_left;
   logic        is_right;

   assign rise      = ock & ~ock_l;
   assign take      = cen & rise & ~old;
   assign done      = take & (bcnt == 4'd15);
   assign short_frm = cen & old & (bcnt != 4'd0);
   assign word_nxt  = {shr[14:0], sio_do};
   assign is_left   = (ashr == LEFT_ADDR);
   assign is_right  = (ashr == RIGHT_ADDR) & ~is_left;

   // Pulse registers hold until the next cen cycle; gating keeps them low when cen is low.
   assign word_valid = vld_p1 & cen;
   assign sample     = smp_p1 & cen;

   // stage p0: edge detect, bit counter and channel pairing state
   always_ff @(posedge clk) begin
      if (rst) begin
         ock_l  <= 1'b0;
         bcnt   <= 4'd0;
         lpend  <= 1'b0;
         vld_p1 <= 1'b0;
         smp_p1 <= 1'b0;
      end else if (cen) begin
         ock_l  <= ock;
         vld_p1 <= done;
         smp_p1 <= done & is_right & lpend;
         if (short_frm)
            bcnt <= 4'd0;
         else if (take)
            bcnt <= bcnt + 4'd1;
         if (done) begin
            if (is_left)
               lpend <= 1'b1;
            else if (is_right)
               lpend <= 1'b0;
         end
      end
   end

   // Shifters: an aborted frame must not leak bits into the next word.
   always_ff @(posedge clk) begin
      if (cen) begin
         if (short_frm) begin
            shr  <= 16'd0;
            ashr <= 8'd0;
         end else if (take) begin
            shr <= word_nxt;
            if (bcnt < 4'd8)
               ashr <= {ashr[6:0], sadd};
         end
      end
   end

   // stage p1: registered word and channel outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         word      <= 16'd0;
         word_addr <= 8'd0;
         left      <= 16'd0;
         right     <= 16'd0;
      end else if (done) begin
         word      <= word_nxt;
         word_addr <= ashr;
         if (is_left)
            left <= word_nxt;
         else if (is_right)
            right <= word_nxt;
      end
   end

`ifdef JTDSP16_SIORX_ERR_EN
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= 8'd0;
      else if (short_frm)
         err_cnt <= sat_inc(err_cnt);
   end
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Self-checking bench for jtdsp16_sio_rx: transmitter model, random cen, frame-level reference model.
`timescale 1ns/1ps
module tb_jtdsp16_sio_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b0;
   logic        ock = 1'b0;
   logic        sio_do = 1'b0;
   logic        sadd = 1'b0;
   logic        old = 1'b1;
   logic [15:0] word;
   logic [7:0]  word_addr;
   logic        word_valid;
   logic [15:0] left;
   logic [15:0] right;
   logic        sample;
   logic [7:0]  err_cnt;

   jtdsp16_sio_rx dut (
      .clk(clk), .rst(rst), .cen(cen), .ock(ock), .sio_do(sio_do), .sadd(sadd), .old(old),
      .word(word), .word_addr(word_addr), .word_valid(word_valid),
      .left(left), .right(right), .sample(sample), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // cen changes just after the edge so it is stable when outputs are sampled at negedge
   always @(posedge clk) begin
      #1 cen = ($urandom_range(0, 2) != 0);
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [15:0] w;
      logic [7:0]  a;
      logic        s;
      logic [15:0] l;
      logic [15:0] r;
   } ev_t;

   ev_t         evq[$];
   logic [15:0] m_left = 16'd0;
   logic [15:0] m_right = 16'd0;
   logic        m_lpend = 1'b0;
   int          m_err = 0;
   int          samp_cnt = 0;
   logic        dbits[64];
   logic        abits[64];
   logic [15:0] fw[4];
   logic [7:0]  fa[4];

   task automatic tick(input int n);
      repeat (n) begin
         do @(posedge clk); while (!cen);
         #2;
      end
   endtask

   task automatic put_word(input int slot, input logic [15:0] d, input logic [7:0] a);
      fw[slot] = d;
      fa[slot] = a;
      for (int i = 0; i < 16; i++) begin
         dbits[slot*16+i] = d[15-i];
         abits[slot*16+i] = (i < 8) ? a[7-i] : 1'($urandom_range(0, 1));
      end
   endtask

   task automatic model_word(input logic [15:0] d, input logic [7:0] a);
      ev_t e;
      e.w = d;
      e.a = a;
      e.s = 1'b0;
      if (a == 8'h00) begin
         m_left = d;
         m_lpend = 1'b1;
      end else if (a == 8'h01) begin
         m_right = d;
         if (m_lpend) begin
            e.s = 1'b1;
            m_lpend = 1'b0;
         end
      end
      e.l = m_left;
      e.r = m_right;
      evq.push_back(e);
   endtask

   task automatic drive_bits(input int nbits);
      old = 1'b1; ock = 1'b0; tick(6);
      ock = 1'b1; tick(6);
      for (int i = 0; i < nbits; i++) begin
         ock = 1'b0; old = 1'b0; sio_do = dbits[i]; sadd = abits[i]; tick(6);
         ock = 1'b1; tick(6);
      end
   endtask

   task automatic send_frame(input int nbits);
      for (int g = 0; g < nbits / 16; g++) model_word(fw[g], fa[g]);
`ifdef JTDSP16_SIORX_ERR_EN
      if (nbits % 16 != 0 && m_err < 255) m_err++;
`endif
      drive_bits(nbits);
      ock = 1'b0; old = 1'b1; tick(3);
      chk("words_pending", evq.size(), 0);
      chk("err_cnt", err_cnt, m_err);
      evq.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_word"}, word, 0);
      chk({tag, "_addr"}, word_addr, 0);
      chk({tag, "_left"}, left, 0);
      chk({tag, "_right"}, right, 0);
      chk({tag, "_valid"}, word_valid, 0);
      chk({tag, "_sample"}, sample, 0);
      chk({tag, "_err"}, err_cnt, 0);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (!rst) begin
         if (word_valid || sample) chk("pulse_cen", cen, 1);
         if (sample) samp_cnt++;
         if (word_valid) begin
            if (evq.size() == 0) begin
               chk("spurious_valid", word_valid, 0);
            end else begin
               e = evq.pop_front();
               chk("word", word, e.w);
               chk("word_addr", word_addr, e.a);
               chk("sample", sample, e.s);
               chk("left", left, e.l);
               chk("right", right, e.r);
            end
         end else begin
            chk("sample_wo_valid", sample, 0);
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      int s0;
      int nb;
      int sel;
      logic [7:0] a;
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      put_word(0, 16'hA5C3, 8'h00); s0 = samp_cnt; send_frame(16);
      chk("t1_left", left, 16'hA5C3);
      chk("t1_nosample", samp_cnt - s0, 0);

      s0 = samp_cnt;
      put_word(0, 16'h1234, 8'h00); send_frame(16);
      put_word(0, 16'hFEDC, 8'h01); send_frame(16);
      chk("t2_right", right, 16'hFEDC);
      chk("t2_sample_once", samp_cnt - s0, 1);

      s0 = samp_cnt;
      put_word(0, 16'h1111, 8'h01); send_frame(16);
      put_word(0, 16'h2222, 8'h01); send_frame(16);
      chk("t3_right", right, 16'h2222);
      chk("t3_nosample", samp_cnt - s0, 0);

      put_word(0, 16'($urandom), 8'h00); send_frame(7);
      put_word(0, 16'h8001, 8'h00); send_frame(16);
      chk("t4_left", left, 16'h8001);

      put_word(0, 16'hABCD, 8'h01);
      drive_bits(9);
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0; ock = 1'b0; old = 1'b1;
      m_left = 16'd0; m_right = 16'd0; m_lpend = 1'b0; m_err = 0; evq.delete();
      @(negedge clk);
      check_reset_outputs("midrst");
      tick(3);
      put_word(0, 16'h0F0F, 8'h00); send_frame(16);
      chk("t5_word", word, 16'h0F0F);

      s0 = samp_cnt;
      put_word(0, 16'h5555, 8'h7E); send_frame(16);
      chk("t6_left", left, 16'h0F0F);
      chk("t6_right", right, 16'h0000);
      chk("t6_nosample", samp_cnt - s0, 0);

      put_word(0, 16'hC0DE, 8'h01); put_word(1, 16'hBEEF, 8'h00); send_frame(32);
      chk("t7_left", left, 16'hBEEF);

      for (int k = 0; k < 30; k++) begin
         sel = $urandom_range(0, 9);
         nb = (sel < 6) ? 16 : (sel < 8) ? 32 : $urandom_range(1, 15);
         for (int g = 0; g < 2; g++) begin
            case ($urandom_range(0, 2))
               0: a = 8'h00;
               1: a = 8'h01;
               default: a = 8'($urandom);
            endcase
            put_word(g, 16'($urandom), a);
         end
         send_frame(nb);
      end
      chk("final_left", left, m_left);
      chk("final_right", right, m_right);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
